// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // The iteration counter must be able to hold the value n itself.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational (k+1)-bit trial subtractor for one restoring-division step.
module div_trial_sub #(
    parameter int k = 16
) (
    input  logic [k-1:0] minuend,
    input  logic [k-1:0] subtrahend,
    output logic [k-1:0] diff,
    output logic         negative
);

    logic [k:0] wide;

    assign wide     = {1'b0, minuend} - {1'b0, subtrahend};
    assign diff     = wide[k-1:0];
    assign negative = wide[k];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// Start/Busy/Done handshake, divide-by-zero flagged without iterating.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int n = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] Q,
    output logic [n-1:0] R,
    output logic         Busy,
    output logic         Done,
    output logic         DivByZero
);

    localparam int count_w = count_width(n);

    div_state_t         state;
    logic [count_w-1:0] count;
    logic [n-1:0]       rem;
    logic [n-1:0]       quo;
    logic [n-1:0]       divisor;

    logic [n:0]         rem_shift;
    logic [n-1:0]       trial_diff;
    logic               trial_neg;
    logic               fits;
    logic [n-1:0]       rem_next;
    logic [n-1:0]       quo_next;

    assign rem_shift = {rem, quo[n-1]};

    div_trial_sub #(
        .k(n)
    ) u_trial (
        .minuend    (rem_shift[n-1:0]),
        .subtrahend (divisor),
        .diff       (trial_diff),
        .negative   (trial_neg)
    );

    // A carry out of the shift would mean the divisor always fits; it cannot
    // happen for an n-bit dividend, but honouring it keeps the step exact.
    assign fits     = rem_shift[n] | ~trial_neg;
    assign rem_next = fits ? trial_diff : rem_shift[n-1:0];
    assign quo_next = {quo[n-2:0], fits};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            Q         <= '0;
            R         <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        Busy <= 1'b1;
                        if (B != '0) begin
                            quo     <= A;
                            divisor <= B;
                            rem     <= '0;
                            count   <= count_w'(n);
                            state   <= CALC;
                        end else begin
                            Q         <= '1;
                            R         <= A;
                            DivByZero <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - 1'b1;
                    if (count == count_w'(1)) begin
                        Q         <= quo_next;
                        R         <= rem_next;
                        DivByZero <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
